// File: rtl/norm_argmax_reader.sv
// norm_argmax_reader: consumer end of the normalization stage. It accepts one
// vector of NUM_CLASSES unsigned scores per valid/ready handshake, scans it one
// class per cycle and presents the arg-max result on a valid/ready port.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   in_vector holds a valid vector
//   in_ready   block can accept a vector (state == IDLE)
//   in_vector  class k at bits [DATA_W*k +: DATA_W]
//   out_valid  result fields are valid
//   out_ready  downstream accepts the result
//   out_class  index of the maximum score (lowest index on a tie)
//   out_score  the maximum score
//   out_tie    another class equals the maximum
//   out_zero   every score was zero
//   out_seq    wrapping result sequence number
module norm_argmax_reader #(
  parameter int unsigned NUM_CLASSES = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned IDX_W       = $clog2(NUM_CLASSES),
  parameter int unsigned SEQ_W       = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W*NUM_CLASSES-1:0] in_vector,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              out_class,
  output logic [DATA_W-1:0]             out_score,
  output logic                          out_tie,
  output logic                          out_zero,
  output logic [SEQ_W-1:0]              out_seq
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

  state_e                          state_q;
  logic [DATA_W*NUM_CLASSES-1:0]   vec_q;
  logic [IDX_W-1:0]                scan_idx_q;
  logic [DATA_W-1:0]               best_val_q;
  logic [IDX_W-1:0]                best_idx_q;
  logic                            tie_q;
  logic                            any_nz_q;

  // One comparison step against the currently scanned class.
  logic [DATA_W-1:0] cur_score;
  logic [DATA_W-1:0] nxt_val;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_tie;
  logic              nxt_nz;

  always_comb begin
    cur_score = vec_q[int'(scan_idx_q)*DATA_W +: DATA_W];
    nxt_val   = best_val_q;
    nxt_idx   = best_idx_q;
    nxt_tie   = tie_q;
    nxt_nz    = any_nz_q | (cur_score != '0);
    if (cur_score > best_val_q) begin
      nxt_val = cur_score;
      nxt_idx = scan_idx_q;
      nxt_tie = 1'b0;
    end else if (cur_score == best_val_q) begin
      nxt_tie = 1'b1;  // keep the lower index
    end
  end

  assign in_ready = (state_q == StIdle);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      scan_idx_q <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      tie_q      <= 1'b0;
      any_nz_q   <= 1'b0;
      out_valid  <= 1'b0;
      out_class  <= '0;
      out_score  <= '0;
      out_tie    <= 1'b0;
      out_zero   <= 1'b0;
      out_seq    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            vec_q      <= in_vector;
            best_val_q <= in_vector[DATA_W-1:0];
            best_idx_q <= '0;
            tie_q      <= 1'b0;
            any_nz_q   <= (in_vector[DATA_W-1:0] != '0);
            scan_idx_q <= IDX_W'(1);
            state_q    <= StScan;
          end
        end
        StScan: begin
          if (scan_idx_q == LastIdx) begin
            // Final comparison lands directly in the output registers.
            out_valid <= 1'b1;
            out_class <= nxt_idx;
            out_score <= nxt_val;
            out_tie   <= nxt_tie;
            out_zero  <= ~nxt_nz;
            state_q   <= StDone;
          end else begin
            best_val_q <= nxt_val;
            best_idx_q <= nxt_idx;
            tie_q      <= nxt_tie;
            any_nz_q   <= nxt_nz;
            scan_idx_q <= scan_idx_q + IDX_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_seq   <= out_seq + SEQ_W'(1);
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/norm_argmax_reader.md
Name: norm_argmax_reader

Overview:
- Consumer end of the normalization stage's output vector.
- Accepts one normalized class-score vector per valid/ready handshake. Scans it serially, one class per cycle, for the maximum score.
- Presents the winning class index, its score, a tie flag, an all-zero flag and a wrapping sequence number on a valid/ready output port.
- Sits between the normalizer and the classification result consumer (host register file / decision logic).

Parameters:
- NUM_CLASSES, 8, number of class scores per vector; must be at least 2.
- DATA_W, 16, width of one normalized score (matches `NORM_OUT_WIDTH). Scores are unsigned.
- IDX_W, 3, width of the class index; equals ceil(log2(NUM_CLASSES)).
- SEQ_W, 8, width of the result sequence counter.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_vector holds a valid normalized vector.
- in_ready  out  1  block can accept a vector.
- in_vector  in  DATA_W*NUM_CLASSES  class k occupies bits [DATA_W*k+DATA_W-1 : DATA_W*k].
- out_valid  out  1  result fields are valid.
- out_ready  in  1  downstream accepts the result.
- out_class  out  IDX_W  index of the maximum score.
- out_score  out  DATA_W  the maximum score.
- out_tie  out  1  another class equals the maximum.
- out_zero  out  1  every score in the vector was zero.
- out_seq  out  SEQ_W  sequence number of this result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - out_valid, out_class, out_score, out_tie, out_zero and out_seq are all 0.
  - The captured vector and the scan index are cleared.
  - While reset is low, in_valid is ignored.
- FSM states are IDLE, SCAN and DONE.
- in_ready is combinational and equals (state==IDLE). It is therefore 1 during and after reset.
- IDLE:
  - On an edge with in_valid=1, capture in_vector into an internal register.
  - Set best_val=score[0], best_idx=0, tie=0, scan_idx=1, any_nonzero=(score[0]!=0). Go to SCAN.
- SCAN: each edge examines captured score[scan_idx].
  - If it is strictly greater than best_val (unsigned): best_val=score, best_idx=scan_idx, tie=0.
  - If it is equal to best_val: tie=1, and best_idx is unchanged (lowest index wins).
  - any_nonzero |= (score != 0).
  - If scan_idx==NUM_CLASSES-1: go to DONE on the same edge, with the final comparison folded into the output registers. Otherwise scan_idx+1.
- Latency: out_valid rises NUM_CLASSES-1 edges after the accepting edge. This is 7 cycles for the defaults.
- DONE:
  - out_valid=1. out_class, out_score, out_tie, out_zero (= !any_nonzero) and out_seq are held stable until accepted.
  - On an edge with out_ready=1: out_valid=0, state=IDLE, out_seq increments.
  - out_seq wraps from 2^SEQ_W-1 to 0.
  - The result fields keep their last values after acceptance; only out_valid drops.
- All-zero vector: out_zero=1, out_class=0, out_score=0, out_tie=1.
- Throughput: one vector per NUM_CLASSES+1 cycles when out_ready is held high. There is no overlap between IDLE accept and DONE.
- Back-pressure: while in DONE, in_ready=0 and upstream must hold its vector. out_ready is ignored outside DONE.
- Changes to in_vector after the accepting edge do not affect the result.
- Reset mid-SCAN or mid-DONE: the result is discarded, out_valid drops immediately, out_seq returns to 0, and the next accepted vector starts a fresh scan.
- The first result after reset carries out_seq=0.

Test Plan:
- Reset, then vector {k0..k7}={10,20,300,40,5,6,7,8} with in_valid for one cycle -> in_ready=0 for 8 cycles. out_valid rises 7 edges after accept with out_class=2, out_score=300, out_tie=0, out_zero=0, out_seq=0.
- Vector with score 500 at classes 3 and 6, all others 1 -> out_class=3, out_score=500, out_tie=1.
- All-zero vector -> out_class=0, out_score=0, out_tie=1, out_zero=1.
- Maximum 16'hFFFF at class 7 only -> out_class=7, out_score=16'hFFFF, out_tie=0.
- Hold out_ready=0 for 20 cycles in DONE -> fields stable, in_ready=0, a new in_valid is not accepted. After out_ready=1 for one edge, out_valid=0 and in_ready=1.
- 257 back-to-back vectors with out_ready=1 -> out_seq runs 0..255, then 0. Asserting reset=0 mid-SCAN drops out_valid at once, and the next result carries out_seq=0.
